writeback_unit: RTL
===================

Name: writeback_unit

Overview:
- Parametrised writeback stage; successor to the fixed 32-bit, single-source writeback.
- Merges two result sources into one registered regfile write port:
  - in-order pipeline results;
  - out-of-order-latency load responses from a multi-cycle data memory.
- Tracks outstanding loads in a small in-order queue, aligns and sign/zero-extends load data per recorded size/offset, and raises a load-use hazard stall to decode.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- REGW, 6, register index width.
- LQ_DEPTH, 2, max outstanding loads; power of two, >=2.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  async active-low reset
- i_wb_valid  in  1  pipeline result valid
- i_wb_rd  in  REGW  pipeline destination register
- i_wb_data  in  XLEN  pipeline result data
- o_wb_ready  out  1  pipeline result accepted this cycle
- i_ld_issue  in  1  load issued to dmem this cycle
- i_ld_rd  in  REGW  load destination register
- i_ld_size  in  2  0=B 1=H 2=W 3=D
- i_ld_unsigned  in  1  zero-extend when 1
- i_ld_offset  in  log2(XLEN/8)  byte offset within the XLEN word
- o_ld_ready  out  1  queue can accept an issue
- i_dmem_rvalid  in  1  load response valid; not back-pressurable
- i_dmem_rdata  in  XLEN  raw load response word
- i_hz_rs1  in  REGW  decode source register 1
- i_hz_rs2  in  REGW  decode source register 2
- o_hz_stall  out  1  source matches a pending load rd
- o_rf_we  out  1  regfile write enable
- o_rf_rd  out  REGW  regfile write index
- o_rf_wdata  out  XLEN  regfile write data
- o_err  out  1  sticky: response with empty queue

Behaviour:
- Reset (async assert, sync deassert): queue empty, o_rf_we=0, o_rf_rd=0, o_rf_wdata=0, o_err=0. Reset mid-operation discards all pending loads; responses after reset set o_err.
- Load queue: FIFO of {rd, size, unsigned, offset}.
  - Push on i_ld_issue && o_ld_ready.
  - Pop on i_dmem_rvalid; responses return in issue order.
  - o_ld_ready = !full. Conservative: a same-cycle pop does not free space.
  - Issue while full is a caller error; the entry is dropped.
- Alignment, with sh = offset*8 and right-shift of rdata:
  - B: shift by offset; extend bit 7.
  - H: offset low bit forced 0; extend bit 15.
  - W: offset low 2 bits forced 0; extend bit 31. At XLEN=32, result is rdata unchanged.
  - D: pass through. At XLEN=32, D is treated as W.
  - Misaligned offsets are silently aligned down.
- Arbitration, same cycle: a load response always wins; o_wb_ready = !i_dmem_rvalid. A stalled pipeline result must be held by the producer.
- Response with empty queue: no write; o_err set and held until reset. A same-cycle issue is not bypassed.
- Write port, 1-cycle latency: on the edge after an accepted source, o_rf_we=1 and o_rf_rd/o_rf_wdata are taken from the winner.
  - Writes to rd==0 are suppressed (o_rf_we=0).
  - Idle cycle: o_rf_we=0; rd/wdata hold their last value.
- Hazard: o_hz_stall is combinational. It is 1 if a nonzero rs1/rs2 equals the rd of any valid queue entry, or of the entry being pushed this cycle. An entry popped this cycle still counts; its value is not yet in the regfile.

Optional Feature:
- Macro: WRITEBACK_FWD_EN.
- When defined:
  - Adds outputs o_fwd_valid, o_fwd_rd, o_fwd_data: the combinational winner (post-alignment, x0 suppressed), one cycle ahead of the regfile write.
  - o_hz_stall excludes an entry whose response arrives this cycle.
- When undefined: ports absent; hazard behaviour as above.

Decomposition:
- Package writeback_pkg:
  - ld_size_e enum (B/H/W/D);
  - ld_entry_t struct;
  - LD_SIZE_W constant;
  - function ld_align(rdata, size, unsigned, offset).
- Sub-module ld_queue: parametrised FIFO holding ld_entry_t, exposing full/empty and per-entry rd/valid for the hazard compare.

Test Plan:
- Reset, then i_wb_valid rd=5 data=0x1234 -> next cycle o_rf_we=1, rd=5, wdata=0x00001234; o_wb_ready=1.
- Issue lb rd=3 offset=2 signed; later rvalid rdata=0x00800000 -> rf write rd=3, 0xFFFFFF80. Same with unsigned=1 -> 0x00000080.
- XLEN=64: lw offset=4, rdata=0x8000000100000000 -> 0xFFFFFFFF80000001; lwu -> 0x0000000080000001.
- Same-cycle rvalid and i_wb_valid -> load written first, o_wb_ready=0; pipeline result written on the following cycle.
- LQ_DEPTH=2: two issues -> o_ld_ready=0. i_hz_rs1 matches first rd -> o_hz_stall=1 until one cycle after its response (with WRITEBACK_FWD_EN, 0 on the response cycle).
- rvalid with empty queue -> no write, o_err=1 held. Assert i_rst_n=0 with a pending load -> queue empty, all outputs zero.

Source files
------------

// File: rtl/writeback_pkg.sv
// Shared types and the load-alignment helper for writeback_unit.
package writeback_pkg;

    localparam int LD_SIZE_W    = 2;
    localparam int LD_RD_MAX_W  = 8;  // widest supported REGW
    localparam int LD_OFF_MAX_W = 3;  // byte offset within a 64-bit word

    typedef enum logic [LD_SIZE_W-1:0] {
        LD_B = 2'd0,
        LD_H = 2'd1,
        LD_W = 2'd2,
        LD_D = 2'd3
    } ld_size_e;

    typedef struct packed {
        logic [LD_RD_MAX_W-1:0]  rd;
        ld_size_e                size;
        logic                    is_unsigned;
        logic [LD_OFF_MAX_W-1:0] offset;
    } ld_entry_t;

    // Works on a 64-bit view; 32-bit callers zero-extend rdata and keep the low half.
    function automatic logic [63:0] ld_align(
        input logic [63:0]             rdata,
        input ld_size_e                size,
        input logic                    is_unsigned,
        input logic [LD_OFF_MAX_W-1:0] offset,
        input logic                    xlen64
    );
        ld_size_e                eff_size;
        logic [LD_OFF_MAX_W-1:0] off;
        logic [63:0]             sh;
        logic [63:0]             res;
        eff_size = (size == LD_D && !xlen64) ? LD_W : size;
        off      = offset;
        if (!xlen64) off[2] = 1'b0;
        case (eff_size)
            LD_H:    off[0]   = 1'b0;
            LD_W:    off[1:0] = 2'b00;
            LD_D:    off      = '0;
            default: ;
        endcase
        sh = rdata >> {off, 3'b000};
        case (eff_size)
            LD_B:    res = {{56{~is_unsigned & sh[7]}},  sh[7:0]};
            LD_H:    res = {{48{~is_unsigned & sh[15]}}, sh[15:0]};
            LD_W:    res = {{32{~is_unsigned & sh[31]}}, sh[31:0]};
            default: res = rdata;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/ld_queue.sv
// In-order outstanding-load FIFO with per-slot rd/valid taps for the hazard compare.
module ld_queue
    import writeback_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int REGW  = 6
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_push,
    input  ld_entry_t                  i_entry,
    input  logic                       i_pop,
    output ld_entry_t                  o_head,
    output logic [$clog2(DEPTH)-1:0]   o_rd_ptr,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [DEPTH-1:0]           o_valid,
    output logic [DEPTH-1:0][REGW-1:0] o_rd
);
    localparam int PTR_W = $clog2(DEPTH);

    ld_entry_t        mem_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic             push_en;
    logic             pop_en;

    assign o_full  = &valid_q;
    assign o_empty = ~|valid_q;
    assign push_en = i_push && !o_full;
    assign pop_en  = i_pop && !o_empty;

    // NOTE: every always_comb target gets a default first so no latch is inferred.
    always_comb begin
        valid_d = valid_q;
        if (pop_en)  valid_d[rd_ptr_q] = 1'b0;
        if (push_en) valid_d[wr_ptr_q] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            valid_q <= valid_d;
            if (push_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_en)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

    // NOTE: payload storage is not reset; valid_q alone decides whether a slot is meaningful.
    always_ff @(posedge i_clk) begin
        if (push_en) mem_q[wr_ptr_q] <= i_entry;
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) o_rd[i] = mem_q[i].rd[REGW-1:0];
    end

    assign o_head   = mem_q[rd_ptr_q];
    assign o_rd_ptr = rd_ptr_q;
    assign o_valid  = valid_q;

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: merges pipeline results and queued load responses into one registered regfile port.
// Optional macro WRITEBACK_FWD_EN adds forwarding outputs and releases the hazard on the response cycle.
module writeback_unit
    import writeback_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int REGW     = 6,
    parameter int LQ_DEPTH = 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_wb_valid,
    input  logic [REGW-1:0]            i_wb_rd,
    input  logic [XLEN-1:0]            i_wb_data,
    output logic                       o_wb_ready,
    input  logic                       i_ld_issue,
    input  logic [REGW-1:0]            i_ld_rd,
    input  logic [LD_SIZE_W-1:0]       i_ld_size,
    input  logic                       i_ld_unsigned,
    input  logic [$clog2(XLEN/8)-1:0]  i_ld_offset,
    output logic                       o_ld_ready,
    input  logic                       i_dmem_rvalid,
    input  logic [XLEN-1:0]            i_dmem_rdata,
    input  logic [REGW-1:0]            i_hz_rs1,
    input  logic [REGW-1:0]            i_hz_rs2,
    output logic                       o_hz_stall,
    output logic                       o_rf_we,
    output logic [REGW-1:0]            o_rf_rd,
    output logic [XLEN-1:0]            o_rf_wdata,
    output logic                       o_err
`ifdef WRITEBACK_FWD_EN
    ,
    output logic                       o_fwd_valid,
    output logic [REGW-1:0]            o_fwd_rd,
    output logic [XLEN-1:0]            o_fwd_data
`endif
);
    localparam int PTR_W = $clog2(LQ_DEPTH);

    ld_entry_t                     issue_entry;
    ld_entry_t                     head;
    logic                          q_full;
    logic                          q_empty;
    logic [PTR_W-1:0]              q_rd_ptr;
    logic [LQ_DEPTH-1:0]           q_valid;
    logic [LQ_DEPTH-1:0][REGW-1:0] q_rd;
    logic [LQ_DEPTH-1:0]           live;
    logic                          push;
    logic                          pop;
    logic [63:0]                   aligned64;
    logic                          win_valid;
    logic                          win_we;
    logic [REGW-1:0]               win_rd;
    logic [XLEN-1:0]               win_data;
    logic                          hz_stall;
    logic                          rf_we_q;
    logic [REGW-1:0]               rf_rd_q;
    logic [XLEN-1:0]               rf_wdata_q;
    logic                          err_q;
    logic                          unused_bits;

    // A pop never frees space for a same-cycle push; issue while full is dropped.
    assign push       = i_ld_issue && !q_full;
    assign pop        = i_dmem_rvalid && !q_empty;
    assign o_ld_ready = !q_full;
    assign o_wb_ready = !i_dmem_rvalid;

    always_comb begin
        issue_entry             = '0;
        issue_entry.rd          = LD_RD_MAX_W'(i_ld_rd);
        issue_entry.size        = ld_size_e'(i_ld_size);
        issue_entry.is_unsigned = i_ld_unsigned;
        issue_entry.offset      = LD_OFF_MAX_W'(i_ld_offset);
    end

    ld_queue #(.DEPTH(LQ_DEPTH), .REGW(REGW)) u_ld_queue (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_push   (push),
        .i_entry  (issue_entry),
        .i_pop    (pop),
        .o_head   (head),
        .o_rd_ptr (q_rd_ptr),
        .o_full   (q_full),
        .o_empty  (q_empty),
        .o_valid  (q_valid),
        .o_rd     (q_rd)
    );

    assign aligned64 = ld_align(64'(i_dmem_rdata), head.size, head.is_unsigned, head.offset,
                                XLEN == 64);

    always_comb begin
        win_valid = 1'b0;
        win_rd    = '0;
        win_data  = '0;
        if (pop) begin
            win_valid = 1'b1;
            win_rd    = head.rd[REGW-1:0];
            win_data  = aligned64[XLEN-1:0];
        end else if (i_wb_valid && o_wb_ready) begin
            win_valid = 1'b1;
            win_rd    = i_wb_rd;
            win_data  = i_wb_data;
        end
    end

    assign win_we = win_valid && (win_rd != '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rf_we_q    <= 1'b0;
            rf_rd_q    <= '0;
            rf_wdata_q <= '0;
            err_q      <= 1'b0;
        end else begin
            rf_we_q <= win_we;
            if (win_we) begin
                rf_rd_q    <= win_rd;
                rf_wdata_q <= win_data;
            end
            if (i_dmem_rvalid && q_empty) err_q <= 1'b1;
        end
    end

    // A popping entry still stalls unless its data can be forwarded this cycle.
    always_comb begin
        live = q_valid;
`ifdef WRITEBACK_FWD_EN
        if (pop) live[q_rd_ptr] = 1'b0;
`endif
        hz_stall = 1'b0;
        for (int i = 0; i < LQ_DEPTH; i++) begin
            if (live[i] && ((i_hz_rs1 != '0 && q_rd[i] == i_hz_rs1) ||
                            (i_hz_rs2 != '0 && q_rd[i] == i_hz_rs2)))
                hz_stall = 1'b1;
        end
        if (push && ((i_hz_rs1 != '0 && i_ld_rd == i_hz_rs1) ||
                     (i_hz_rs2 != '0 && i_ld_rd == i_hz_rs2)))
            hz_stall = 1'b1;
    end

    assign o_hz_stall  = hz_stall;
    assign o_rf_we     = rf_we_q;
    assign o_rf_rd     = rf_rd_q;
    assign o_rf_wdata  = rf_wdata_q;
    assign o_err       = err_q;
    assign unused_bits = ^{head.rd, aligned64, q_rd_ptr};

`ifdef WRITEBACK_FWD_EN
    assign o_fwd_valid = win_we;
    assign o_fwd_rd    = win_rd;
    assign o_fwd_data  = win_data;
`endif

endmodule
